// File: rtl/scl_por_schmitt_lvl.sv
// Clocked power-on-reset conditioner: 2-FF input synchronizer, two cascaded
// saturating-integrator Schmitt stages, and a gated HV-to-LV output register.
module scl_por_schmitt_lvl #(
    parameter int CNT_W = 4,
    parameter int TH_HI = 12,
    parameter int TH_LO = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic inode,
    input  logic lv_ok,
    output logic mid,
    output logic porb_h,
    output logic porb_l,
    output logic por_l
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TH_HI_C  = CNT_W'(TH_HI);
    localparam logic [CNT_W-1:0] TH_LO_C  = CNT_W'(TH_LO);

    // Thresholds must define a non-empty hysteresis band inside the counter range.
    if ((TH_LO < 0) || (TH_LO >= TH_HI) || (TH_HI > (2**CNT_W) - 1)) begin : g_bad_params
        $error("scl_por_schmitt_lvl: illegal threshold parameters");
    end

    // Saturating up/down integrator step; never wraps at either end.
    function automatic logic [CNT_W-1:0] cnt_step(input logic din, input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (din) begin
            res = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end else begin
            res = (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
        end
        return res;
    endfunction

    // Schmitt decision on the new count; holds the old output inside the band.
    function automatic logic out_step(input logic [CNT_W-1:0] cnt_n, input logic out_cur);
        logic res;
        if (cnt_n >= TH_HI_C) begin
            res = 1'b1;
        end else if (cnt_n <= TH_LO_C) begin
            res = 1'b0;
        end else begin
            res = out_cur;
        end
        return res;
    endfunction

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;
    logic             mid_q, mid_d;
    logic             porb_h_q, porb_h_d;
    logic             lsq_q;

    // Next-state for both hysteresis stages; stage 2 listens only to the registered stage-1 output.
    always_comb begin
        cnt1_d   = cnt_step(s2_q, cnt1_q);
        mid_d    = out_step(cnt1_d, mid_q);
        cnt2_d   = cnt_step(mid_q, cnt2_q);
        porb_h_d = out_step(cnt2_d, porb_h_q);
    end

    // All state: synchronizer, integrators, stage outputs and the level-shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt1_q   <= CNT_ZERO;
            cnt2_q   <= CNT_ZERO;
            mid_q    <= 1'b0;
            porb_h_q <= 1'b0;
            lsq_q    <= 1'b0;
        end else begin
            s1_q     <= inode;
            s2_q     <= s1_q;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            mid_q    <= mid_d;
            porb_h_q <= porb_h_d;
            lsq_q    <= porb_h_q;
        end
    end

    // The LV gate is combinational so losing the LV supply asserts reset without a clock.
    always_comb begin
        mid    = mid_q;
        porb_h = porb_h_q;
        porb_l = lsq_q & lv_ok;
        por_l  = ~(lsq_q & lv_ok);
    end

endmodule

// File: tb/tb_scl_por_schmitt_lvl.sv
// Self-checking bench for scl_por_schmitt_lvl: scoreboard of per-edge expectations
// plus a table of asynchronous gate/reset vectors.
module tb_scl_por_schmitt_lvl;

    logic clk = 1'b0;
    logic resetn, inode, lv_ok;
    logic mid, porb_h, porb_l, por_l;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int   edge_n;
        logic m;
        logic ph;
        logic pl;
        int   cnt1;
    } exp_t;

    typedef struct {
        logic rst;
        logic lv;
        logic in;
        logic m;
        logic ph;
        logic pl;
        logic pr;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];

    scl_por_schmitt_lvl dut (
        .clk    (clk),
        .resetn (resetn),
        .inode  (inode),
        .lv_ok  (lv_ok),
        .mid    (mid),
        .porb_h (porb_h),
        .porb_l (porb_l),
        .por_l  (por_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic push(input int e, input logic m, input logic ph, input logic pl, input int c);
        exp_t x;
        x.edge_n = e; x.m = m; x.ph = ph; x.pl = pl; x.cnt1 = c;
        sb.push_back(x);
    endtask

    task automatic tick_check(input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 4'd1, 4'd0);
        end else begin
            x = sb.pop_front();
            chk($sformatf("%s e%0d mid", tag, x.edge_n), {3'b0, mid}, {3'b0, x.m});
            chk($sformatf("%s e%0d porb_h", tag, x.edge_n), {3'b0, porb_h}, {3'b0, x.ph});
            chk($sformatf("%s e%0d porb_l", tag, x.edge_n), {3'b0, porb_l}, {3'b0, x.pl});
            chk($sformatf("%s e%0d por_l", tag, x.edge_n), {3'b0, por_l}, {3'b0, ~x.pl});
            if (x.cnt1 >= 0) begin
                chk($sformatf("%s e%0d cnt1", tag, x.edge_n), dut.cnt1_q, 4'(x.cnt1));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{rst:1'b1, lv:1'b0, in:1'b1, m:1'b1, ph:1'b1, pl:1'b0, pr:1'b1};
        tbl[1] = '{rst:1'b1, lv:1'b1, in:1'b1, m:1'b1, ph:1'b1, pl:1'b1, pr:1'b0};
        tbl[2] = '{rst:1'b1, lv:1'b0, in:1'b1, m:1'b1, ph:1'b1, pl:1'b0, pr:1'b1};
        tbl[3] = '{rst:1'b1, lv:1'b1, in:1'b1, m:1'b1, ph:1'b1, pl:1'b1, pr:1'b0};
        tbl[4] = '{rst:1'b0, lv:1'b1, in:1'b1, m:1'b0, ph:1'b0, pl:1'b0, pr:1'b1};
        tbl[5] = '{rst:1'b0, lv:1'b0, in:1'b1, m:1'b0, ph:1'b0, pl:1'b0, pr:1'b1};
        tbl[6] = '{rst:1'b0, lv:1'b1, in:1'b1, m:1'b0, ph:1'b0, pl:1'b0, pr:1'b1};

        resetn = 1'b1;
        inode  = 1'b1;
        lv_ok  = 1'b1;

        // Reset applied with inode high, checked before any clock edge.
        #2 resetn = 1'b0;
        #1;
        chk("reset mid", {3'b0, mid}, 4'd0);
        chk("reset porb_h", {3'b0, porb_h}, 4'd0);
        chk("reset porb_l", {3'b0, porb_l}, 4'd0);
        chk("reset por_l", {3'b0, por_l}, 4'd1);

        // Power-up ramp: inode already high at release, so the next edge is edge 1.
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            push(e, e >= 14, e >= 26, e >= 27, (e >= 3 && e <= 17) ? e - 2 : (e > 17 ? 15 : 0));
        end
        for (int e = 1; e <= 32; e++) tick_check("powerup");

        // Power-down from saturation.
        inode = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            push(e, e < 14, e < 26, e < 27, (e >= 2 && e <= 17) ? 17 - e : (e > 17 ? 0 : 15));
        end
        for (int e = 1; e <= 30; e++) tick_check("powerdown");

        // Re-saturate both stages.
        inode = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        chk("resat mid", {3'b0, mid}, 4'd1);
        chk("resat porb_l", {3'b0, porb_l}, 4'd1);
        chk("resat cnt1", dut.cnt1_q, 4'd15);

        // Hysteresis: short dropout takes cnt1 down to 4 only; outputs must not move.
        inode = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            push(e, 1'b1, 1'b1, 1'b1, (e == 13) ? 4 : ((e >= 24) ? 15 : -1));
        end
        for (int e = 1; e <= 30; e++) begin
            if (e == 12) inode = 1'b1;
            tick_check("hyst");
        end

        // LV gate and asynchronous reset vectors, each checked before the next clock edge.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            resetn = tbl[i].rst;
            lv_ok  = tbl[i].lv;
            inode  = tbl[i].in;
            #1;
            chk($sformatf("vec%0d mid", i), {3'b0, mid}, {3'b0, tbl[i].m});
            chk($sformatf("vec%0d porb_h", i), {3'b0, porb_h}, {3'b0, tbl[i].ph});
            chk($sformatf("vec%0d porb_l", i), {3'b0, porb_l}, {3'b0, tbl[i].pl});
            chk($sformatf("vec%0d por_l", i), {3'b0, por_l}, {3'b0, tbl[i].pr});
        end

        // Reset mid-ramp clears the integrator; the ramp then restarts from zero.
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= 8; e++) push(e, 1'b0, 1'b0, 1'b0, (e >= 3) ? e - 2 : 0);
        for (int e = 1; e <= 8; e++) tick_check("midramp");
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midramp rst cnt1", dut.cnt1_q, 4'd0);
        chk("midramp rst por_l", {3'b0, por_l}, 4'd1);
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= 16; e++) push(e, e >= 14, 1'b0, 1'b0, -1);
        for (int e = 1; e <= 16; e++) tick_check("restart");

        // Glitch: 5-cycle pulse cannot reach the set threshold.
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            push(e, 1'b0, 1'b0, 1'b0, (e == 7) ? 5 : ((e == 8) ? 4 : ((e >= 12) ? 0 : -1)));
        end
        for (int e = 1; e <= 20; e++) begin
            if (e == 6) inode = 1'b0;
            tick_check("glitch");
        end

        chk("scoreboard drained", 4'(sb.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
